// File: rtl/sha256_mem_hasher.sv
// Multi-block SHA-256 engine: reads a NUM_OF_WORDS-word message from a shared single-port
// word memory, pads it in hardware, hashes every block and writes the 8-word digest back.
// Latency: (use_midstate ? 8+L : 0) + B*(81+L) + 9 cycles per job. Memory has fixed read
// latency L, so there is no backpressure; start is ignored unless the engine is idle.
//
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   start, use_midstate  job request (sampled in IDLE only) and initial-hash source select
//   message_addr         word address of message word 0
//   midstate_addr        word address of the 8 midstate words (use_midstate=1 only)
//   output_addr          word address of digest word 0
//   busy, done           job in progress / one-cycle completion pulse
//   mem_*                memory port; mem_read_data is valid MEM_READ_LATENCY cycles after mem_addr
module sha256_mem_hasher #(
    parameter int NUM_OF_WORDS     = 20,
    parameter int MEM_READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        use_midstate,
    input  logic [15:0] message_addr,
    input  logic [15:0] midstate_addr,
    input  logic [15:0] output_addr,
    output logic        busy,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);
    // One 0x80000000 word plus two length words must fit after the message.
    localparam int          NUM_BLOCKS = (NUM_OF_WORDS + 3 + 15) / 16;
    localparam int          PAD_WORDS  = NUM_BLOCKS * 16;
    localparam logic [15:0] N16        = 16'(NUM_OF_WORDS);
    localparam logic [15:0] LAST_IDX   = 16'(PAD_WORDS - 1);
    localparam logic [15:0] LAST_BLK   = 16'(PAD_WORDS - 16);
    localparam logic [31:0] BIT_LEN    = 32'(NUM_OF_WORDS * 32);
    localparam logic [5:0]  LAT        = 6'(MEM_READ_LATENCY);
    localparam logic [5:0]  MID_END    = 6'(7 + MEM_READ_LATENCY);
    localparam logic [5:0]  FETCH_END  = 6'(15 + MEM_READ_LATENCY);

    localparam logic [31:0] H_INIT [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef enum logic [2:0] {
        IDLE, LOADMID, FETCH, COMPUTE, UPDATE, WRITE, DONE
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t      state;
    logic [5:0]  cnt;          // cycle/round counter within the current state
    logic [15:0] blk_base;     // padded-stream index of word 0 of the current block
    logic [15:0] msg_base;
    logic [15:0] out_base;
    logic [31:0] hash [0:7];
    logic [31:0] wv   [0:7];   // working variables a..h
    logic [31:0] w    [0:15];  // schedule window, w[0] is the word for the current round

    logic [31:0] big_s0, big_s1, ch, maj, t1, t2, w_next;
    logic [31:0] hash_sum [0:7];
    logic [15:0] fetch_idx, rd_idx, next_blk;
    logic [31:0] fetch_word;

    assign mem_clk = clk;

    always_comb begin
        big_s1 = rotr(wv[4], 6) ^ rotr(wv[4], 11) ^ rotr(wv[4], 25);
        big_s0 = rotr(wv[0], 2) ^ rotr(wv[0], 13) ^ rotr(wv[0], 22);
        ch     = (wv[4] & wv[5]) ^ (~wv[4] & wv[6]);
        maj    = (wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]);
        t1     = wv[7] + big_s1 + ch + K[cnt] + w[0];
        t2     = big_s0 + maj;
        // Window holds W[t..t+15]; produce W[t+16] as it slides.
        w_next = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
               + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
        for (int i = 0; i < 8; i++) begin
            hash_sum[i] = hash[i] + wv[i];
        end

        // Word arriving now was addressed LAT cycles earlier.
        fetch_idx = blk_base + {10'd0, cnt - LAT};
        rd_idx    = blk_base + {10'd0, cnt} + 16'd1;
        next_blk  = blk_base + 16'd16;

        // The upper length word is always zero for a 16-bit word count, so it
        // falls into the zero-fill case.
        if (fetch_idx < N16) begin
            fetch_word = mem_read_data;
        end else if (fetch_idx == N16) begin
            fetch_word = 32'h80000000;
        end else if (fetch_idx == LAST_IDX) begin
            fetch_word = BIT_LEN;
        end else begin
            fetch_word = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            blk_base       <= '0;
            msg_base       <= '0;
            out_base       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            for (int i = 0; i < 8; i++) begin
                hash[i] <= '0;
                wv[i]   <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                w[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        msg_base <= message_addr;
                        out_base <= output_addr;
                        blk_base <= '0;
                        cnt      <= '0;
                        if (use_midstate) begin
                            state    <= LOADMID;
                            mem_addr <= midstate_addr;
                        end else begin
                            state    <= FETCH;
                            mem_addr <= message_addr;
                            for (int i = 0; i < 8; i++) begin
                                hash[i] <= H_INIT[i];
                            end
                        end
                    end
                end

                LOADMID: begin
                    if (cnt < 6'd7) begin
                        mem_addr <= mem_addr + 16'd1;
                    end
                    if (cnt >= LAT) begin
                        for (int i = 0; i < 7; i++) begin
                            hash[i] <= hash[i + 1];
                        end
                        hash[7] <= mem_read_data;
                    end
                    if (cnt == MID_END) begin
                        state    <= FETCH;
                        cnt      <= '0;
                        mem_addr <= msg_base;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end

                // Fixed 16+L cycles per block; padding words never touch memory.
                FETCH: begin
                    if (cnt < 6'd15 && rd_idx < N16) begin
                        mem_addr <= msg_base + rd_idx;
                    end
                    if (cnt >= LAT) begin
                        for (int i = 0; i < 15; i++) begin
                            w[i] <= w[i + 1];
                        end
                        w[15] <= fetch_word;
                    end
                    if (cnt == FETCH_END) begin
                        state <= COMPUTE;
                        cnt   <= '0;
                        for (int i = 0; i < 8; i++) begin
                            wv[i] <= hash[i];
                        end
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end

                COMPUTE: begin
                    wv[7] <= wv[6];
                    wv[6] <= wv[5];
                    wv[5] <= wv[4];
                    wv[4] <= wv[3] + t1;
                    wv[3] <= wv[2];
                    wv[2] <= wv[1];
                    wv[1] <= wv[0];
                    wv[0] <= t1 + t2;
                    for (int i = 0; i < 15; i++) begin
                        w[i] <= w[i + 1];
                    end
                    w[15] <= w_next;
                    if (cnt == 6'd63) begin
                        state <= UPDATE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end

                UPDATE: begin
                    for (int i = 0; i < 8; i++) begin
                        hash[i] <= hash_sum[i];
                    end
                    cnt <= '0;
                    if (blk_base != LAST_BLK) begin
                        state    <= FETCH;
                        blk_base <= next_blk;
                        if (next_blk < N16) begin
                            mem_addr <= msg_base + next_blk;
                        end
                    end else begin
                        // First digest word comes from the sum, not the stale register.
                        state          <= WRITE;
                        mem_we         <= 1'b1;
                        mem_addr       <= out_base;
                        mem_write_data <= hash_sum[0];
                    end
                end

                WRITE: begin
                    if (cnt == 6'd7) begin
                        state  <= DONE;
                        mem_we <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        mem_addr       <= mem_addr + 16'd1;
                        mem_write_data <= hash[cnt[2:0] + 3'd1];
                        cnt            <= cnt + 6'd1;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
